flash_sample_reader: RTL and testbench
======================================

Name: flash_sample_reader

Overview:
- Upstream stage of the audio playback path. Reads signed 16-bit mono samples from the DE2 8-bit parallel flash.
- Each sample is two consecutive bytes, low byte at the even address. The sample is presented on data/valid and advanced by a four-phase valid/next handshake.
- The playback FSM consumes each sample and forwards it to audio_codec.
- After NUM_SAMPLES samples have been consumed, the block asserts done and idles the flash.

Parameters:
- START_ADDR, 22'h000000: byte address of the first sample; must be even.
- NUM_SAMPLES, 2097152: number of 16-bit samples to play. START_ADDR + 2*NUM_SAMPLES must not exceed 2^22 (elaboration assertion).
- WAIT_CYCLES, 5: CLOCK_50 cycles per byte access, 100 ns at the default. Must be at least 1.

Ports:
- CLOCK_50  in  1  system clock; all logic on posedge.
- resetb  in  1  reset, synchronous, active-low.
- FL_ADDR  out  22  flash byte address.
- FL_CE_N  out  1  flash chip enable, active-low.
- FL_DQ  inout  8  flash data; this block only reads it and always drives high-Z.
- FL_OE_N  out  1  flash output enable, active-low.
- FL_RST_N  out  1  flash hardware reset, active-low.
- FL_WE_N  out  1  flash write enable; constant 1.
- data  out  16  current sample, {high byte, low byte}.
- valid  out  1  data holds a new sample.
- next  in  1  consumer acknowledge.
- done  out  1  all samples consumed; sticky until reset.

Behaviour:
- Reset, sampled on posedge while resetb=0:
  - state=FETCH_LO, FL_ADDR=START_ADDR, sample index=0, wait counter=0.
  - FL_CE_N=1, FL_OE_N=1, FL_RST_N=0.
  - valid=0, done=0, data=0.
- Reset asserted mid-operation abandons any fetch or handshake; the block restarts from START_ADDR.
- FL_WE_N=1 and FL_DQ=Z at all times. FL_RST_N=1 on every cycle after reset.
- FETCH_LO:
  - FL_CE_N=0, FL_OE_N=0, FL_ADDR stable for WAIT_CYCLES cycles.
  - On the edge ending the WAIT_CYCLES-th cycle: capture FL_DQ into the low byte, increment FL_ADDR, go to FETCH_HI.
- FETCH_HI:
  - Same access timing as FETCH_LO; capture into the high byte and increment FL_ADDR.
  - At that same edge, data <= {FL_DQ, low byte}.
  - If next=0: valid <= 1, go to PRESENT. Otherwise go to HOLD.
- HOLD (consumer still acknowledging the previous sample):
  - Flash deselected: FL_CE_N=1, FL_OE_N=1.
  - The first edge with next=0 sets valid <= 1 and goes to PRESENT.
- PRESENT:
  - Flash deselected; valid=1; data held stable.
  - On an edge with next=1: valid <= 0 and the sample index increments.
  - If the index was NUM_SAMPLES-1, go to DONE. Otherwise go to FETCH_LO, so prefetch overlaps the consumer's handshake.
- DONE:
  - done=1, valid=0, flash deselected; absorbing until reset.
- Latency and throughput:
  - valid first rises 2*WAIT_CYCLES cycles after the first edge with resetb=1.
  - valid falls exactly 1 cycle after next is sampled high.
  - Minimum sample period is 2*WAIT_CYCLES+1 cycles when next is a one-cycle pulse.
- Handshake rules:
  - valid never rises while next=1.
  - next is ignored outside PRESENT, except that HOLD waits for it to go low.
  - One sample is delivered per valid-rise / next-high pair, even if next stays high for many cycles.
- Width rules:
  - FL_ADDR increments modulo 2^22; the parameter assertion prevents wrap in legal configurations.
  - The sample index is $clog2(NUM_SAMPLES+1) bits wide.
  - The wait counter is $clog2(WAIT_CYCLES+1) bits wide and clears on every byte capture.

Decomposition:
- Package flash_reader_pkg:
  - State enum: FETCH_LO, FETCH_HI, HOLD, PRESENT, DONE.
  - Constants FLASH_ADDR_W=22, FLASH_DATA_W=8, SAMPLE_W=16.
- Sub-module flash_byte_fetch:
  - Inputs start and addr.
  - Drives CE_N/OE_N, counts WAIT_CYCLES, returns byte with a one-cycle byte_done.
  - The top FSM sequences two fetches per sample.

Test Plan:
- Basic read, with START_ADDR=0, WAIT_CYCLES=5, NUM_SAMPLES=3 and flash model bytes 34 12 CD AB 00 80:
  - Reset release → valid rises after 10 cycles with data=16'h1234.
  - FL_OE_N is low throughout both fetches; FL_ADDR steps 0→1→2.
- Single-cycle next pulses → data sequence 16'h1234, 16'hABCD, 16'h8000.
  - valid falls one cycle after each next.
  - done=1 one cycle after the third next, with FL_CE_N=1 thereafter.
- next held high for 20 cycles after the first sample:
  - Second fetch completes, then the block waits in HOLD with valid=0.
  - valid rises the cycle after next drops, with data=16'hABCD.
- Reset (resetb=0 for one edge) during FETCH_HI of sample 2:
  - valid=0, FL_ADDR=0, FL_RST_N=0 that cycle.
  - Replay starts with 16'h1234.
- START_ADDR=22'h3FFFFC, NUM_SAMPLES=2:
  - Reads addresses 3FFFFC–3FFFFF, done after the second handshake, no address wrap.
  - FL_WE_N=1 and FL_DQ=Z throughout.

Source files
------------

// File: rtl/flash_reader_pkg.sv
// Shared types and widths for the parallel-flash sample reader.
// Sample assembly and address stepping helpers live here so both modules agree.
package flash_reader_pkg;

   localparam int FLASH_ADDR_W = 22;
   localparam int FLASH_DATA_W = 8;
   localparam int SAMPLE_W     = 16;

   typedef enum logic [2:0] {
      FETCH_LO = 3'd0,
      FETCH_HI = 3'd1,
      HOLD     = 3'd2,
      PRESENT  = 3'd3,
      DONE     = 3'd4
   } state_e;

   function automatic logic [FLASH_ADDR_W-1:0] addr_inc(input logic [FLASH_ADDR_W-1:0] a);
      return a + 22'd1;
   endfunction

   function automatic logic [SAMPLE_W-1:0] join_bytes(input logic [FLASH_DATA_W-1:0] hi,
                                                       input logic [FLASH_DATA_W-1:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/flash_byte_fetch.sv
// One timed byte read from the parallel flash: selects the part while start_i is high
// and flags the edge that ends each WAIT_CYCLES-long access with byte_done_o.
module flash_byte_fetch
   import flash_reader_pkg::*;
#(
   parameter int WAIT_CYCLES = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    start_i,
   input  logic [FLASH_ADDR_W-1:0] addr_i,
   input  logic [FLASH_DATA_W-1:0] dq_i,
   output logic [FLASH_ADDR_W-1:0] fl_addr_o,
   output logic                    ce_n_o,
   output logic                    oe_n_o,
   output logic [FLASH_DATA_W-1:0] byte_o,
   output logic                    byte_done_o
);

   localparam int                CNT_W    = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

   logic             ce_n_q;
   logic             oe_n_q;
   logic [CNT_W-1:0] cnt_q;

   // start_i is the caller's next-cycle request, so deselect lands on the capture edge itself
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ce_n_q <= 1'b1;
         oe_n_q <= 1'b1;
         cnt_q  <= '0;
      end else if (!start_i) begin
         ce_n_q <= 1'b1;
         oe_n_q <= 1'b1;
         cnt_q  <= '0;
      end else if (ce_n_q) begin
         ce_n_q <= 1'b0;
         oe_n_q <= 1'b0;
         cnt_q  <= '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_q  <= '0;
      end else begin
         cnt_q  <= cnt_q + CNT_W'(1);
      end
   end

   assign fl_addr_o   = addr_i;
   assign ce_n_o      = ce_n_q;
   assign oe_n_o      = oe_n_q;
   assign byte_o      = dq_i;
   assign byte_done_o = !ce_n_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/flash_sample_reader.sv
// Streams signed 16-bit samples (low byte at even address) out of the DE2 parallel flash
// through a four-phase valid/next handshake, then parks in DONE with the flash idle.
module flash_sample_reader
   import flash_reader_pkg::*;
#(
   parameter logic [FLASH_ADDR_W-1:0] START_ADDR  = 22'h000000,
   parameter int                      NUM_SAMPLES = 2097152,
   parameter int                      WAIT_CYCLES = 5
) (
   input  logic                    CLOCK_50,
   input  logic                    resetb,
   output logic [FLASH_ADDR_W-1:0] FL_ADDR,
   output logic                    FL_CE_N,
   inout  wire  [FLASH_DATA_W-1:0] FL_DQ,
   output logic                    FL_OE_N,
   output logic                    FL_RST_N,
   output logic                    FL_WE_N,
   output logic [SAMPLE_W-1:0]     data,
   output logic                    valid,
   input  logic                    next,
   output logic                    done
);

   localparam int                IDX_W    = $clog2(NUM_SAMPLES + 1);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SAMPLES - 1);
   localparam longint unsigned   END_ADDR = 64'(START_ADDR) + 64'd2 * 64'(NUM_SAMPLES);

   if ((END_ADDR > 64'd4194304) || (START_ADDR[0] != 1'b0) ||
       (WAIT_CYCLES < 1) || (NUM_SAMPLES < 1)) begin : g_param_error
      $error("flash_sample_reader: illegal START_ADDR/NUM_SAMPLES/WAIT_CYCLES combination");
   end

   state_e                  state_q;
   logic [FLASH_ADDR_W-1:0] addr_q;
   logic [IDX_W-1:0]        idx_q;
   logic [FLASH_DATA_W-1:0] lo_q;
   logic [SAMPLE_W-1:0]     data_q;
   logic                    valid_q;
   logic                    done_q;
   logic                    fl_rst_n_q;

   logic                    fetch_req_s;
   logic                    byte_done_s;
   logic [FLASH_DATA_W-1:0] byte_s;

   flash_byte_fetch #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_fetch (
      .clk_i       (CLOCK_50),
      .rst_n_i     (resetb),
      .start_i     (fetch_req_s),
      .addr_i      (addr_q),
      .dq_i        (FL_DQ),
      .fl_addr_o   (FL_ADDR),
      .ce_n_o      (FL_CE_N),
      .oe_n_o      (FL_OE_N),
      .byte_o      (byte_s),
      .byte_done_o (byte_done_s)
   );

   // Ask for flash access whenever the FSM will be in a fetch state next cycle
   always_comb begin
      fetch_req_s = 1'b0;
      case (state_q)
         FETCH_LO: fetch_req_s = 1'b1;
         FETCH_HI: fetch_req_s = !byte_done_s;
         PRESENT:  fetch_req_s = next && (idx_q != LAST_IDX);
         default:  fetch_req_s = 1'b0;
      endcase
   end

   // Sample sequencing and handshake
   always_ff @(posedge CLOCK_50) begin
      if (!resetb) begin
         state_q    <= FETCH_LO;
         addr_q     <= START_ADDR;
         idx_q      <= '0;
         lo_q       <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         fl_rst_n_q <= 1'b0;
      end else begin
         fl_rst_n_q <= 1'b1;
         case (state_q)
            FETCH_LO: begin
               if (byte_done_s) begin
                  lo_q    <= byte_s;
                  addr_q  <= addr_inc(addr_q);
                  state_q <= FETCH_HI;
               end
            end
            FETCH_HI: begin
               if (byte_done_s) begin
                  addr_q <= addr_inc(addr_q);
                  data_q <= join_bytes(byte_s, lo_q);
                  // consumer may still be acknowledging the previous sample
                  if (!next) begin
                     valid_q <= 1'b1;
                     state_q <= PRESENT;
                  end else begin
                     state_q <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (!next) begin
                  valid_q <= 1'b1;
                  state_q <= PRESENT;
               end
            end
            PRESENT: begin
               if (next) begin
                  valid_q <= 1'b0;
                  idx_q   <= idx_q + IDX_W'(1);
                  if (idx_q == LAST_IDX) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     state_q <= FETCH_LO;
                  end
               end
            end
            DONE: begin
               valid_q <= 1'b0;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= FETCH_LO;
            end
         endcase
      end
   end

   assign FL_DQ    = 8'hzz;
   assign FL_WE_N  = 1'b1;
   assign FL_RST_N = fl_rst_n_q;
   assign data     = data_q;
   assign valid    = valid_q;
   assign done     = done_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Two reader instances (small image at 0, and a top-of-flash image) against a byte-array
// flash model; expected samples and timing come from the byte image and handshake rules.
module tb_flash_sample_reader;

   localparam logic [21:0] S0 = 22'h000000;
   localparam int          N0 = 3;
   localparam int          W0 = 5;
   localparam logic [21:0] S1 = 22'h3FFFFC;
   localparam int          N1 = 2;
   localparam int          W1 = 3;

   logic        clk = 1'b0;
   logic        resetb [2];
   logic        nxt    [2];
   logic [21:0] fl_addr[2];
   logic        ce_n   [2];
   logic        oe_n   [2];
   logic        frst_n [2];
   logic        we_n   [2];
   logic [15:0] data   [2];
   logic        valid  [2];
   logic        done   [2];
   wire  [7:0]  dq0;
   wire  [7:0]  dq1;
   logic [7:0]  mem [2][8];
   logic [21:0] off0;
   logic [21:0] off1;

   int ncmp  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   assign off0 = fl_addr[0] - S0;
   assign off1 = fl_addr[1] - S1;
   assign dq0  = (!ce_n[0] && !oe_n[0]) ? mem[0][off0[2:0]] : 8'hzz;
   assign dq1  = (!ce_n[1] && !oe_n[1]) ? mem[1][off1[2:0]] : 8'hzz;

   flash_sample_reader #(.START_ADDR(S0), .NUM_SAMPLES(N0), .WAIT_CYCLES(W0)) u_dut0 (
      .CLOCK_50(clk), .resetb(resetb[0]), .FL_ADDR(fl_addr[0]), .FL_CE_N(ce_n[0]),
      .FL_DQ(dq0), .FL_OE_N(oe_n[0]), .FL_RST_N(frst_n[0]), .FL_WE_N(we_n[0]),
      .data(data[0]), .valid(valid[0]), .next(nxt[0]), .done(done[0]));

   flash_sample_reader #(.START_ADDR(S1), .NUM_SAMPLES(N1), .WAIT_CYCLES(W1)) u_dut1 (
      .CLOCK_50(clk), .resetb(resetb[1]), .FL_ADDR(fl_addr[1]), .FL_CE_N(ce_n[1]),
      .FL_DQ(dq1), .FL_OE_N(oe_n[1]), .FL_RST_N(frst_n[1]), .FL_WE_N(we_n[1]),
      .data(data[1]), .valid(valid[1]), .next(nxt[1]), .done(done[1]));

   function automatic int wc(input int k);
      return (k == 0) ? W0 : W1;
   endfunction

   function automatic int nc(input int k);
      return (k == 0) ? N0 : N1;
   endfunction

   function automatic logic [21:0] sa(input int k);
      return (k == 0) ? S0 : S1;
   endfunction

   function automatic logic [15:0] exp_sample(input int k, input int i);
      return {mem[k][2*i+1], mem[k][2*i]};
   endfunction

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // advance one edge, then check the always-true pin rules on both instances
   task automatic tick();
      logic [21:0] o;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check("we_n_high", k, {31'd0, we_n[k]}, 32'd1);
         if (oe_n[k] === 1'b1)
            check("dq_hiz", k, {24'd0, (k == 0) ? dq0 : dq1}, {24'd0, 8'hzz});
         if (ce_n[k] === 1'b0) begin
            o = fl_addr[k] - sa(k);
            check("addr_in_image", k, {31'd0, (o < 22'(2 * nc(k)))}, 32'd1);
         end
      end
   endtask

   task automatic reset_check(input int k);
      resetb[k] = 1'b0;
      tick();
      check("rst_valid", k, {31'd0, valid[k]}, 32'd0);
      check("rst_done",  k, {31'd0, done[k]},  32'd0);
      check("rst_data",  k, {16'd0, data[k]},  32'd0);
      check("rst_ce_n",  k, {31'd0, ce_n[k]},  32'd1);
      check("rst_oe_n",  k, {31'd0, oe_n[k]},  32'd1);
      check("rst_flrst", k, {31'd0, frst_n[k]}, 32'd0);
      check("rst_addr",  k, {10'd0, fl_addr[k]}, {10'd0, sa(k)});
   endtask

   task automatic expect_first(input int k);
      int w;
      w = wc(k);
      resetb[k] = 1'b1;
      tick();
      check("e0_ce_n",  k, {31'd0, ce_n[k]},   32'd0);
      check("e0_oe_n",  k, {31'd0, oe_n[k]},   32'd0);
      check("e0_flrst", k, {31'd0, frst_n[k]}, 32'd1);
      check("e0_addr",  k, {10'd0, fl_addr[k]}, {10'd0, sa(k)});
      for (int n = 1; n <= 2 * w; n++) begin
         tick();
         if (n < 2 * w) begin
            check("first_valid_low", k, {31'd0, valid[k]}, 32'd0);
            check("first_oe_low",    k, {31'd0, oe_n[k]},  32'd0);
            check("first_addr",      k, {10'd0, fl_addr[k]}, {10'd0, sa(k) + 22'(n >= w)});
         end else begin
            check("first_valid", k, {31'd0, valid[k]}, 32'd1);
            check("first_data",  k, {16'd0, data[k]},  {16'd0, exp_sample(k, 0)});
            check("first_desel", k, {31'd0, ce_n[k]},  32'd1);
            check("first_addr2", k, {10'd0, fl_addr[k]}, {10'd0, sa(k) + 22'd2});
         end
      end
   endtask

   // sample i is on the bus: wait g cycles, raise next for h edges, follow the next sample
   task automatic handshake(input int k, input int i, input int g, input int h);
      int w;
      int t;
      int exp_lat;
      logic [21:0] base;
      w = wc(k);
      repeat (g) begin
         tick();
         check("present_valid", k, {31'd0, valid[k]}, 32'd1);
         check("present_data",  k, {16'd0, data[k]},  {16'd0, exp_sample(k, i)});
      end
      nxt[k] = 1'b1;
      tick();
      check("valid_fall", k, {31'd0, valid[k]}, 32'd0);
      if (i + 1 == nc(k)) begin
         check("done_set",   k, {31'd0, done[k]}, 32'd1);
         check("done_desel", k, {31'd0, ce_n[k]}, 32'd1);
         repeat (4) begin
            tick();
            check("done_sticky", k, {31'd0, done[k]},  32'd1);
            check("done_valid",  k, {31'd0, valid[k]}, 32'd0);
            check("done_idle",   k, {31'd0, ce_n[k]},  32'd1);
         end
         nxt[k] = 1'b0;
         tick();
         check("done_sticky2", k, {31'd0, done[k]}, 32'd1);
      end else begin
         base = sa(k) + 22'(2 * (i + 1));
         exp_lat = (h > 2 * w) ? h : 2 * w;
         for (t = 1; t <= 4 * w + h + 8; t++) begin
            if (t == h) nxt[k] = 1'b0;
            tick();
            if (valid[k] === 1'b1) break;
            if (t < 2 * w) begin
               check("fetch_oe_low", k, {31'd0, oe_n[k]}, 32'd0);
               check("fetch_addr",   k, {10'd0, fl_addr[k]}, {10'd0, base + 22'(t >= w)});
            end else begin
               check("hold_desel", k, {31'd0, ce_n[k]}, 32'd1);
            end
         end
         check("latency",       k, t, exp_lat);
         check("sample",        k, {16'd0, data[k]}, {16'd0, exp_sample(k, i + 1)});
         check("present_desel", k, {31'd0, ce_n[k]}, 32'd1);
         nxt[k] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the sequence completed");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetb[0] = 1'b0;
      resetb[1] = 1'b0;
      nxt[0]    = 1'b0;
      nxt[1]    = 1'b0;
      mem[0][0] = 8'h34; mem[0][1] = 8'h12;
      mem[0][2] = 8'hCD; mem[0][3] = 8'hAB;
      mem[0][4] = 8'h00; mem[0][5] = 8'h80;
      mem[0][6] = 8'($urandom); mem[0][7] = 8'($urandom);
      for (int j = 0; j < 8; j++) mem[1][j] = 8'($urandom);

      tick();
      reset_check(0);
      reset_check(1);

      // fixed image, single-cycle acknowledges, through to done
      expect_first(0);
      handshake(0, 0, 0, 1);
      handshake(0, 1, 2, 1);
      handshake(0, 2, 1, 1);

      // next held for 20 cycles forces HOLD, then reset in the middle of a high-byte fetch
      reset_check(0);
      expect_first(0);
      handshake(0, 0, 0, 20);
      nxt[0] = 1'b1;
      tick();
      nxt[0] = 1'b0;
      repeat (W0 + 2) tick();
      check("mid_hi_selected", 0, {31'd0, ce_n[0]}, 32'd0);
      check("mid_hi_addr",     0, {10'd0, fl_addr[0]}, {10'd0, S0 + 22'd5});
      reset_check(0);
      expect_first(0);

      // randomized presentation gaps and acknowledge lengths
      handshake(0, 0, int'($urandom_range(0, 3)), int'($urandom_range(1, 3 * W0)));
      handshake(0, 1, int'($urandom_range(0, 3)), int'($urandom_range(1, 3 * W0)));
      handshake(0, 2, int'($urandom_range(0, 3)), int'($urandom_range(1, 3 * W0)));

      // top-of-flash image with random bytes
      expect_first(1);
      handshake(1, 0, int'($urandom_range(0, 3)), int'($urandom_range(1, 3 * W1)));
      handshake(1, 1, int'($urandom_range(0, 3)), int'($urandom_range(1, 3 * W1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
